alarm_controller: RTL

- Central anti-theft FSM of the car alarm. It drives the countdown timer through start_timer/timer_value and consumes expired/one_hz_enable from it.
- Decides arming, entry delay, siren and disarm from ignition and door switches.
- Holds the four user-reprogrammable delay values and sits between switch debouncers and siren/LED drivers.

---
 rtl/alarm_controller_pkg.sv | 31 +++
 rtl/alarm_controller_if.sv | 28 ++
 rtl/alarm_controller_param_regs.sv | 34 +++
 rtl/alarm_controller.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared encodings and default delays for the car alarm controller.
package alarm_controller_pkg;

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_ALARM      = 3'd2,
    ST_ALARM_HOLD = 3'd3,
    ST_DIS_IGN    = 3'd4,
    ST_DIS_WAIT   = 3'd5,
    ST_DIS_DOOR   = 3'd6,
    ST_ARM_WAIT   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    SEL_ARM       = 2'd0,
    SEL_DRIVER    = 2'd1,
    SEL_PASSENGER = 2'd2,
    SEL_ALARM_ON  = 2'd3
  } param_sel_e;

  localparam logic [3:0] DEF_ARM_DELAY       = 4'd6;
  localparam logic [3:0] DEF_DRIVER_DELAY    = 4'd8;
  localparam logic [3:0] DEF_PASSENGER_DELAY = 4'd15;
  localparam logic [3:0] DEF_ALARM_ON        = 4'd10;

  function automatic logic siren_on(state_e s);
    return (s == ST_ALARM) || (s == ST_ALARM_HOLD);
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Switch, reprogram, timer handshake and indicator signals of the alarm controller.
interface alarm_controller_if;
  logic       ignition;
  logic       door_driver;
  logic       door_pass;
  logic       reprogram;
  logic [1:0] param_sel;
  logic [3:0] param_value;
  logic       expired;
  logic       one_hz_enable;
  logic       start_timer;
  logic [3:0] timer_value;
  logic       siren;
  logic       status_led;
  logic [2:0] state_dbg;

  modport master (
    input  ignition, door_driver, door_pass, reprogram, param_sel, param_value,
           expired, one_hz_enable,
    output start_timer, timer_value, siren, status_led, state_dbg
  );

  modport slave (
    output ignition, door_driver, door_pass, reprogram, param_sel, param_value,
           expired, one_hz_enable,
    input  start_timer, timer_value, siren, status_led, state_dbg
  );
endinterface

// File: rtl/alarm_controller_param_regs.sv
// 4x4-bit user-programmable delay registers with one write port and one read mux.
module alarm_controller_param_regs
  import alarm_controller_pkg::*;
#(
  parameter logic [3:0] T_ARM_DELAY       = DEF_ARM_DELAY,
  parameter logic [3:0] T_DRIVER_DELAY    = DEF_DRIVER_DELAY,
  parameter logic [3:0] T_PASSENGER_DELAY = DEF_PASSENGER_DELAY,
  parameter logic [3:0] T_ALARM_ON        = DEF_ALARM_ON
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] wsel,
  input  logic [3:0] wdata,
  input  logic [1:0] rsel,
  output logic [3:0] rdata
);

  logic [3:0][3:0] regs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs[SEL_ARM]       <= T_ARM_DELAY;
      regs[SEL_DRIVER]    <= T_DRIVER_DELAY;
      regs[SEL_PASSENGER] <= T_PASSENGER_DELAY;
      regs[SEL_ALARM_ON]  <= T_ALARM_ON;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  assign rdata = regs[rsel];

endmodule

// File: rtl/alarm_controller.sv
// Anti-theft FSM: arming, entry delay, siren and disarm sequencing; drives the
// countdown timer via a registered one-cycle start pulse.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter logic [3:0] T_ARM_DELAY       = DEF_ARM_DELAY,
  parameter logic [3:0] T_DRIVER_DELAY    = DEF_DRIVER_DELAY,
  parameter logic [3:0] T_PASSENGER_DELAY = DEF_PASSENGER_DELAY,
  parameter logic [3:0] T_ALARM_ON        = DEF_ALARM_ON
) (
  input  logic                clock,
  input  logic                reset,
  alarm_controller_if.master  bus
);

  state_e     state, state_nxt;
  param_sel_e sel_nxt;
  logic       start_q, start_nxt;
  logic [3:0] tval_q, dly;
  logic       led_q, led_nxt;
  logic       exp_ok;

  alarm_controller_param_regs #(
    .T_ARM_DELAY      (T_ARM_DELAY),
    .T_DRIVER_DELAY   (T_DRIVER_DELAY),
    .T_PASSENGER_DELAY(T_PASSENGER_DELAY),
    .T_ALARM_ON       (T_ALARM_ON)
  ) u_regs (
    .clock (clock),
    .reset (reset),
    .we    (bus.reprogram),
    .wsel  (bus.param_sel),
    .wdata (bus.param_value),
    .rsel  (sel_nxt),
    .rdata (dly)
  );

  // The timer reloads one edge after start, so its expired is stale while start is high.
  assign exp_ok = bus.expired && !start_q;

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    sel_nxt   = SEL_ARM;
    if (bus.reprogram) begin
      state_nxt = ST_ARMED;
    end else if (bus.ignition && state != ST_DIS_IGN) begin
      state_nxt = ST_DIS_IGN;
    end else begin
      case (state)
        ST_ARMED: begin
          if (bus.door_driver) begin
            state_nxt = ST_TRIGGERED;
            start_nxt = 1'b1;
            sel_nxt   = SEL_DRIVER;
          end else if (bus.door_pass) begin
            state_nxt = ST_TRIGGERED;
            start_nxt = 1'b1;
            sel_nxt   = SEL_PASSENGER;
          end
        end
        ST_TRIGGERED: if (exp_ok) state_nxt = ST_ALARM;
        ST_ALARM: begin
          if (!bus.door_driver && !bus.door_pass) begin
            state_nxt = ST_ALARM_HOLD;
            start_nxt = 1'b1;
            sel_nxt   = SEL_ALARM_ON;
          end
        end
        ST_ALARM_HOLD: begin
          if (bus.door_driver || bus.door_pass) state_nxt = ST_ALARM;
          else if (exp_ok)                      state_nxt = ST_ARMED;
        end
        ST_DIS_IGN:  if (!bus.ignition)   state_nxt = ST_DIS_WAIT;
        ST_DIS_WAIT: if (bus.door_driver) state_nxt = ST_DIS_DOOR;
        ST_DIS_DOOR: begin
          if (!bus.door_driver) begin
            state_nxt = ST_ARM_WAIT;
            start_nxt = 1'b1;
            sel_nxt   = SEL_ARM;
          end
        end
        ST_ARM_WAIT: begin
          if (bus.door_driver) state_nxt = ST_DIS_DOOR;
          else if (exp_ok)     state_nxt = ST_ARMED;
        end
        default: state_nxt = ST_ARMED;
      endcase
    end
  end

  // LED blink phase restarts at 0 on every entry into ARMED.
  always_comb begin
    led_nxt = 1'b0;
    case (state_nxt)
      ST_ARMED:      led_nxt = (state == ST_ARMED) ? (led_q ^ bus.one_hz_enable) : 1'b0;
      ST_TRIGGERED,
      ST_ALARM,
      ST_ALARM_HOLD: led_nxt = 1'b1;
      default:       led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_ARMED;
      start_q <= 1'b0;
      tval_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start_nxt;
      led_q   <= led_nxt;
      if (start_nxt) tval_q <= dly;
    end
  end

  assign bus.start_timer = start_q;
  assign bus.timer_value = tval_q;
  assign bus.siren       = siren_on(state);
  assign bus.status_led  = led_q;
  assign bus.state_dbg   = state;

endmodule
